// File: rtl/btn_conditioner.sv
// Button conditioner for two raw active-low push buttons: 2-flop sync,
// counter debounce, press/release pulses and a 6-bit press counter on LEDs.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   btn1, btn2   raw buttons, active-low, asynchronous to clk
//   btn1_level   debounced button 1, active-high
//   btn2_level   debounced button 2, active-high
//   btn1_press   one-cycle pulse on debounced press of button 1
//   btn2_press   one-cycle pulse on debounced press of button 2
//   btn1_release one-cycle pulse on debounced release of button 1
//   btn2_release one-cycle pulse on debounced release of button 2
//   led          active-low LED drive, ~press_count
module btn_conditioner #(
    parameter int DB_CYCLES = 540000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn1,
    input  logic       btn2,
    output logic       btn1_level,
    output logic       btn2_level,
    output logic       btn1_press,
    output logic       btn2_press,
    output logic       btn1_release,
    output logic       btn2_release,
    output logic [5:0] led
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

    // Index 0 is button 1, index 1 is button 2.
    logic [1:0]       s1;
    logic [1:0]       s2;
    logic [1:0]       sync;
    logic [1:0]       level;
    logic [1:0]       press;
    logic [1:0]       release_p;
    logic [CNT_W-1:0] cnt [2];
    logic [5:0]       press_count;

    // Inversion after the second stage makes the debouncer work active-high.
    assign sync = ~s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 2'b11;
            s2 <= 2'b11;
        end else begin
            s1 <= {btn2, btn1};
            s2 <= s1;
        end
    end

    // The flip edge also raises the pulse, so the pulse is high exactly in
    // the first cycle of the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level     <= 2'b00;
            press     <= 2'b00;
            release_p <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                press[i]     <= 1'b0;
                release_p[i] <= 1'b0;
                if (sync[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    level[i]     <= sync[i];
                    cnt[i]       <= '0;
                    press[i]     <= sync[i];
                    release_p[i] <= ~sync[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Clear has priority over increment when both pulses coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_count <= 6'd0;
        end else if (press[1]) begin
            press_count <= 6'd0;
        end else if (press[0]) begin
            press_count <= press_count + 6'd1;
        end
    end

    assign btn1_level   = level[0];
    assign btn2_level   = level[1];
    assign btn1_press   = press[0];
    assign btn2_press   = press[1];
    assign btn1_release = release_p[0];
    assign btn2_release = release_p[1];
    assign led          = ~press_count;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DB_CYCLES=4.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_btn_conditioner;

    logic       clk;
    logic       rst_n;
    logic       btn1;
    logic       btn2;
    logic       btn1_level;
    logic       btn2_level;
    logic       btn1_press;
    logic       btn2_press;
    logic       btn1_release;
    logic       btn2_release;
    logic [5:0] led;

    int checks;
    int failures;

    btn_conditioner #(
        .DB_CYCLES(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn1         (btn1),
        .btn2         (btn2),
        .btn1_level   (btn1_level),
        .btn2_level   (btn2_level),
        .btn1_press   (btn1_press),
        .btn2_press   (btn2_press),
        .btn1_release (btn1_release),
        .btn2_release (btn2_release),
        .led          (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        btn1  = 1'b1;
        btn2  = 1'b1;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic press_btn1();
        btn1 = 1'b0;
        tick(7);
        btn1 = 1'b1;
        tick(7);
    endtask

    task automatic test_reset();
        btn1  = 1'b1;
        btn2  = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({btn1_level, btn2_level, btn1_press, btn2_press,
             btn1_release, btn2_release} !== 6'b0 || led !== 6'h3F) begin
            failures++;
            $display("FAIL reset_now: flags=%b led=%b want 0 / 111111",
                {btn1_level, btn2_level, btn1_press, btn2_press,
                 btn1_release, btn2_release}, led);
        end
        btn1 = 1'b0;
        btn2 = 1'b0;
        tick(8);
        checks++;
        if ({btn1_level, btn2_level, btn1_press, btn2_press,
             btn1_release, btn2_release} !== 6'b0 || led !== 6'h3F) begin
            failures++;
            $display("FAIL reset_hold: flags=%b led=%b want 0 / 111111",
                {btn1_level, btn2_level, btn1_press, btn2_press,
                 btn1_release, btn2_release}, led);
        end
        btn1  = 1'b1;
        btn2  = 1'b1;
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_clean_press();
        apply_reset();
        btn1 = 1'b0;
        tick(5);
        checks++;
        if (btn1_level !== 1'b0 || btn1_press !== 1'b0) begin
            failures++;
            $display("FAIL press_early: level=%b press=%b want 0 0",
                btn1_level, btn1_press);
        end
        tick(1);
        checks++;
        if (btn1_level !== 1'b1 || btn1_press !== 1'b1 || led !== 6'h3F) begin
            failures++;
            $display("FAIL press_edge: level=%b press=%b led=%b want 1 1 111111",
                btn1_level, btn1_press, led);
        end
        tick(1);
        checks++;
        if (btn1_press !== 1'b0 || led !== 6'b111110) begin
            failures++;
            $display("FAIL press_after: press=%b led=%b want 0 111110",
                btn1_press, led);
        end
        tick(4);
        checks++;
        if (btn1_level !== 1'b1 || btn1_press !== 1'b0) begin
            failures++;
            $display("FAIL press_hold: level=%b press=%b want 1 0",
                btn1_level, btn1_press);
        end
        btn1 = 1'b1;
        tick(5);
        checks++;
        if (btn1_level !== 1'b1 || btn1_release !== 1'b0) begin
            failures++;
            $display("FAIL rel_early: level=%b release=%b want 1 0",
                btn1_level, btn1_release);
        end
        tick(1);
        checks++;
        if (btn1_level !== 1'b0 || btn1_release !== 1'b1 ||
            btn1_press !== 1'b0) begin
            failures++;
            $display("FAIL rel_edge: level=%b release=%b press=%b want 0 1 0",
                btn1_level, btn1_release, btn1_press);
        end
        tick(1);
        checks++;
        if (btn1_release !== 1'b0 || led !== 6'b111110) begin
            failures++;
            $display("FAIL rel_after: release=%b led=%b want 0 111110",
                btn1_release, led);
        end
    endtask

    task automatic test_bounce();
        logic seen;
        int   pat [4] = '{3, 1, 2, 10};
        apply_reset();
        seen = 1'b0;
        for (int p = 0; p < 4; p++) begin
            btn1 = p[0];
            for (int c = 0; c < pat[p]; c++) begin
                tick(1);
                if (btn1_level || btn1_press || btn1_release) seen = 1'b1;
            end
        end
        checks++;
        if (seen !== 1'b0 || led !== 6'h3F) begin
            failures++;
            $display("FAIL bounce: activity=%b led=%b want 0 111111",
                seen, led);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int n = 1; n <= 63; n++) press_btn1();
        checks++;
        if (led !== 6'b000000) begin
            failures++;
            $display("FAIL wrap_63: led=%b want 000000", led);
        end
        press_btn1();
        checks++;
        if (led !== 6'b111111) begin
            failures++;
            $display("FAIL wrap_64: led=%b want 111111", led);
        end
    endtask

    task automatic test_clear_simul();
        apply_reset();
        for (int n = 0; n < 5; n++) press_btn1();
        checks++;
        if (led !== 6'b111010) begin
            failures++;
            $display("FAIL count5: led=%b want 111010", led);
        end
        btn2 = 1'b0;
        tick(7);
        btn2 = 1'b1;
        tick(7);
        checks++;
        if (led !== 6'b111111) begin
            failures++;
            $display("FAIL clear: led=%b want 111111", led);
        end
        for (int n = 0; n < 3; n++) press_btn1();
        checks++;
        if (led !== 6'b111100) begin
            failures++;
            $display("FAIL count3: led=%b want 111100", led);
        end
        btn1 = 1'b0;
        btn2 = 1'b0;
        tick(6);
        checks++;
        if ({btn1_press, btn2_press, btn1_level, btn2_level} !== 4'b1111) begin
            failures++;
            $display("FAIL simul_press: p1p2l1l2=%b want 1111",
                {btn1_press, btn2_press, btn1_level, btn2_level});
        end
        tick(1);
        checks++;
        if (led !== 6'b111111) begin
            failures++;
            $display("FAIL simul_clear: led=%b want 111111", led);
        end
        btn1 = 1'b1;
        tick(6);
        checks++;
        if ({btn1_release, btn1_level, btn2_level} !== 3'b101) begin
            failures++;
            $display("FAIL indep_rel: r1l1l2=%b want 101",
                {btn1_release, btn1_level, btn2_level});
        end
        btn2 = 1'b1;
        tick(7);
    endtask

    task automatic test_async_reset();
        apply_reset();
        btn1 = 1'b0;
        tick(7);
        checks++;
        if (led !== 6'b111110 || btn1_level !== 1'b1) begin
            failures++;
            $display("FAIL ar_pre: led=%b level=%b want 111110 1",
                led, btn1_level);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (led !== 6'b111111 || btn1_level !== 1'b0) begin
            failures++;
            $display("FAIL ar_now: led=%b level=%b want 111111 0",
                led, btn1_level);
        end
        #1;
        rst_n = 1'b1;
        tick(5);
        checks++;
        if (btn1_press !== 1'b0 || btn1_level !== 1'b0) begin
            failures++;
            $display("FAIL ar_early: press=%b level=%b want 0 0",
                btn1_press, btn1_level);
        end
        tick(1);
        checks++;
        if (btn1_press !== 1'b1) begin
            failures++;
            $display("FAIL ar_press: press=%b want 1", btn1_press);
        end
        tick(1);
        checks++;
        if (led !== 6'b111110 || btn1_press !== 1'b0) begin
            failures++;
            $display("FAIL ar_count: led=%b press=%b want 111110 0",
                led, btn1_press);
        end
        btn1 = 1'b1;
        tick(7);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        btn1     = 1'b1;
        btn2     = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_wrap();
        test_clear_simul();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
